// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: sequences sample shift, per-tap MAC cycles, result handoff and coefficient reload for a shared FIR datapath.
module fir_mac_sequencer #(
  parameter int TAPS = 4,
  parameter int TW   = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          cfg_start,
  output logic          shift_en,
  output logic          acc_clr,
  output logic          acc_en,
  output logic [TW-1:0] tap_sel,
  output logic          coef_we,
  output logic [TW-1:0] coef_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);
  typedef enum logic [2:0] {IDLE, SHIFT, MAC, OUT, LOAD} state_t;
  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          cfg_pend_q, cfg_pend_d;
  logic          last;
  assign last = cnt_q == TW'(TAPS - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cfg_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cfg_pend_q <= cfg_pend_d;
    end
  end
  // A reload request arriving while busy is remembered and served ahead of the next sample.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cfg_pend_d = cfg_pend_q | (cfg_start & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cfg_pend_q) begin
          state_d    = LOAD;
          cfg_pend_d = 1'b0;
        end else if (in_valid) begin
          state_d    = SHIFT;
          cfg_pend_d = cfg_start;
        end else if (cfg_start) begin
          state_d = LOAD;
        end
      end
      SHIFT: begin
        state_d = MAC;
        cnt_d   = '0;
      end
      MAC: begin
        state_d = last ? OUT : MAC;
        cnt_d   = last ? '0 : cnt_q + TW'(1);
      end
      OUT: state_d = out_ready ? IDLE : OUT;
      LOAD: begin
        state_d = last ? IDLE : LOAD;
        cnt_d   = last ? '0 : cnt_q + TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  assign in_ready  = (state_q == IDLE) && !cfg_pend_q;
  assign shift_en  = state_q == SHIFT;
  assign acc_clr   = state_q == SHIFT;
  assign acc_en    = state_q == MAC;
  assign tap_sel   = acc_en ? cnt_q : '0;
  assign coef_we   = state_q == LOAD;
  assign coef_addr = coef_we ? cnt_q : '0;
  assign out_valid = state_q == OUT;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: vector table with a scoreboard queue, plus hand-written reset and TAPS=8 sequences.
module tb_fir_mac_sequencer;
  logic clk = 1'b0;
  logic reset, in_valid, cfg_start, out_ready;
  logic in_ready, shift_en, acc_clr, acc_en, coef_we, out_valid, busy;
  logic [1:0] tap_sel, coef_addr;
  logic in_ready8, shift_en8, acc_clr8, acc_en8, coef_we8, out_valid8, busy8;
  logic [2:0] tap_sel8, coef_addr8;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic       iv;
    logic       cs;
    logic       ordy;
    logic [10:0] ex;
  } vec_t;
  vec_t vecs[$];
  logic [10:0] sb[$];
  logic [10:0] outs;

  fir_mac_sequencer #(.TAPS(4), .TW(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .cfg_start(cfg_start),
    .shift_en(shift_en), .acc_clr(acc_clr), .acc_en(acc_en), .tap_sel(tap_sel), .coef_we(coef_we),
    .coef_addr(coef_addr), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );
  fir_mac_sequencer #(.TAPS(8), .TW(3)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8), .cfg_start(cfg_start),
    .shift_en(shift_en8), .acc_clr(acc_clr8), .acc_en(acc_en8), .tap_sel(tap_sel8), .coef_we(coef_we8),
    .coef_addr(coef_addr8), .out_valid(out_valid8), .out_ready(out_ready), .busy(busy8)
  );

  always #5 clk = ~clk;
  assign outs = {in_ready, shift_en, acc_clr, acc_en, tap_sel, coef_we, coef_addr, out_valid, busy};

  function automatic logic [10:0] e(input logic ir, sh, ac, ae, input logic [1:0] ts, input logic we,
                                    input logic [1:0] ca, input logic ov, bz);
    return {ir, sh, ac, ae, ts, we, ca, ov, bz};
  endfunction
  function automatic logic [10:0] idle_e();   return e(1, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0); endfunction
  function automatic logic [10:0] pend_e();   return e(0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0); endfunction
  function automatic logic [10:0] shift_e();  return e(0, 1, 1, 0, 2'd0, 0, 2'd0, 0, 1); endfunction
  function automatic logic [10:0] out_e();    return e(0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 1); endfunction
  function automatic logic [10:0] mac_e(input int t);  return e(0, 0, 0, 1, 2'(t), 0, 2'd0, 0, 1); endfunction
  function automatic logic [10:0] load_e(input int a); return e(0, 0, 0, 0, 2'd0, 1, 2'(a), 0, 1); endfunction

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {ir,sh,ac,ae,ts,we,ca,ov,bz}=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk1(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic add(input logic iv, input logic cs, input logic ordy, input logic [10:0] ex);
    vecs.push_back('{iv, cs, ordy, ex});
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; cfg_start = 1'b0; out_ready = 1'b0;
    // single sample, result held for 10 cycles; in_valid during OUT is ignored
    add(1, 0, 0, shift_e());
    for (int t = 0; t < 4; t++) add(0, 0, 0, mac_e(t));
    add(0, 0, 0, out_e());
    for (int i = 0; i < 10; i++) add(i[0], 0, 0, out_e());
    add(0, 0, 1, idle_e());
    add(0, 0, 0, idle_e());
    // reload from idle; in_valid during LOAD is ignored
    add(0, 1, 0, load_e(0));
    for (int a = 1; a < 4; a++) add(1, 0, 0, load_e(a));
    add(1, 0, 0, idle_e());
    add(0, 0, 0, idle_e());
    // simultaneous sample and reload request: sample first, then load
    add(1, 1, 1, shift_e());
    for (int t = 0; t < 4; t++) add(0, 0, 0, mac_e(t));
    add(0, 0, 0, out_e());
    add(0, 0, 1, pend_e());
    for (int a = 0; a < 4; a++) add(1, 0, 0, load_e(a));
    add(1, 0, 0, idle_e());
    add(0, 0, 0, idle_e());
    // three reload pulses while busy collapse to one load
    add(1, 0, 1, shift_e());
    add(0, 0, 0, mac_e(0));
    add(0, 1, 0, mac_e(1));
    add(0, 0, 0, mac_e(2));
    add(0, 1, 0, mac_e(3));
    add(0, 1, 0, out_e());
    add(0, 0, 1, pend_e());
    for (int a = 0; a < 4; a++) add(0, 0, 0, load_e(a));
    add(0, 0, 0, idle_e());
    add(0, 0, 0, idle_e());
    add(0, 0, 0, idle_e());

    repeat (2) cyc();
    chk("reset_state", outs, idle_e());
    #2 reset = 1'b0;
    cyc();
    chk("after_reset_idle", outs, idle_e());

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = vecs[i].iv; cfg_start = vecs[i].cs; out_ready = vecs[i].ordy;
      sb.push_back(vecs[i].ex);
      cyc();
      chk($sformatf("vec%0d", i), outs, sb.pop_front());
    end
    in_valid = 1'b0; cfg_start = 1'b0; out_ready = 1'b0;

    // asynchronous reset in the middle of MAC at tap 2
    in_valid = 1'b1; cyc(); in_valid = 1'b0;
    chk("rst_mac_shift", outs, shift_e());
    cyc(); cyc(); cyc();
    chk("rst_mac_tap2", outs, mac_e(2));
    #2 reset = 1'b1;
    #1 chk("rst_mac_async", outs, idle_e());
    #3 reset = 1'b0;
    cyc();
    chk("rst_mac_idle", outs, idle_e());
    in_valid = 1'b1; cyc(); in_valid = 1'b0;
    chk("restart_shift", outs, shift_e());
    cyc();
    chk("restart_tap0", outs, mac_e(0));
    out_ready = 1'b1;
    repeat (5) cyc();
    chk("restart_done", outs, idle_e());
    out_ready = 1'b0;

    // asynchronous reset during LOAD with a pending reload discards both
    cfg_start = 1'b1; cyc(); cfg_start = 1'b0;
    chk("rst_load0", outs, load_e(0));
    cfg_start = 1'b1; cyc(); cfg_start = 1'b0;
    chk("rst_load1", outs, load_e(1));
    #2 reset = 1'b1;
    #1 chk("rst_load_async", outs, idle_e());
    #3 reset = 1'b0;
    cyc();
    chk("rst_load_idle", outs, idle_e());
    cyc();
    chk("rst_load_nopend", outs, idle_e());

    // TAPS=8 instance: eight MAC cycles with tap_sel 0..7
    reset = 1'b1; #2 reset = 1'b0;
    cyc();
    chk1("t8_idle", {busy8, in_ready8, acc_en8, out_valid8}, 4'b0100);
    in_valid = 1'b1; cyc(); in_valid = 1'b0;
    chk1("t8_shift", {busy8, shift_en8, acc_clr8, acc_en8}, 4'b1110);
    for (int t = 0; t < 8; t++) begin
      cyc();
      chk1($sformatf("t8_tap%0d", t), {acc_en8, tap_sel8}, {1'b1, 3'(t)});
    end
    cyc();
    chk1("t8_out", {out_valid8, acc_en8, busy8, in_ready8}, 4'b1010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
- Controller that time-multiplexes one 8x8 multiplier and one accumulator across TAPS filter taps per input sample.
- Sequences sample shift, accumulator clear, per-tap MAC enables and coefficient-RAM load cycles.
- Provides valid/ready handshakes toward the sample source and the result sink.
- Sits between the pad-level wrapper (switch inputs, bidirectional coefficient bus) and the shared FIR datapath (delay line, coefficient bank, MAC, output register).

Parameters:
- TAPS, 4, number of filter taps; legal range 2..16.
- TW, 2, width of tap index; must equal ceil(log2(TAPS)).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  sample source has a sample on the datapath input.
- in_ready  output  1  sequencer accepts a sample this cycle.
- cfg_start  input  1  single-cycle pulse: request reload of all TAPS coefficients.
- shift_en  output  1  datapath pushes the input sample into the delay line.
- acc_clr  output  1  datapath clears the accumulator.
- acc_en  output  1  datapath adds coef[tap_sel]*x[tap_sel] into the accumulator.
- tap_sel  output  TW  tap index for the MAC and coefficient read mux.
- coef_we  output  1  coefficient bank write strobe; data comes from the bidirectional bus.
- coef_addr  output  TW  coefficient bank write address.
- out_valid  output  1  accumulator holds a finished result.
- out_ready  input  1  sink takes the result.
- busy  output  1  sequencer is not in IDLE.

Behaviour:
- The clock is clk. Reset is the signal reset: asynchronous, active-high.
- FSM states: IDLE, SHIFT, MAC, OUT, LOAD.
- Reset values: state=IDLE, tap counter=0, cfg_pend=0. All outputs are 0 except in_ready=1.
- Every output is decoded from registered state only. There is no combinational path from any input to any output.
- in_ready = (state==IDLE) && !cfg_pend.
- A sample handshake occurs at a rising edge where in_valid && in_ready.
- IDLE:
  - cfg_pend=1 -> LOAD, and cfg_pend clears.
  - Otherwise, sample handshake -> SHIFT.
  - Otherwise, cfg_start -> LOAD.
  - Simultaneous cfg_start and handshake: the sample is accepted (-> SHIFT) and cfg_pend is set.
- SHIFT (1 cycle): shift_en=1, acc_clr=1, tap counter loads 0. Next state MAC.
- MAC (TAPS cycles): acc_en=1, tap_sel=counter, counter increments by 1. After the cycle with counter==TAPS-1, next state is OUT and the counter resets to 0.
- OUT: out_valid=1, held until a rising edge with out_ready=1, then -> IDLE. tap_sel=0. The accumulator is not touched.
- LOAD (TAPS cycles): coef_we=1, coef_addr=counter, counter increments by 1. After counter==TAPS-1, -> IDLE. One coefficient is written per cycle, in order 0..TAPS-1.
- cfg_start outside IDLE (any state, including LOAD): sets cfg_pend. Multiple pulses collapse into one pending load. The pending load is served at the next IDLE, before any new sample.
- busy = (state != IDLE).
- Latency: handshake at edge t -> shift_en during cycle t..t+1 -> acc_en during TAPS cycles -> out_valid first high after edge t+TAPS+1. Minimum sample period is TAPS+3 cycles with out_ready tied high.
- No arithmetic in this block. Counter width is TW and never wraps past TAPS-1.
- Reset mid-operation (any state): return to reset values immediately. An in-flight result and any pending load are discarded, and coef_we drops asynchronously.
- in_valid while in_ready=0 is ignored. The source must hold the sample until the handshake.

Test Plan:
- Reset then idle: check in_ready=1, busy=0, all strobes 0. Pulse in_valid for 1 cycle -> shift_en for exactly 1 cycle, then acc_en for 4 cycles with tap_sel=0,1,2,3, then out_valid=1.
- Hold out_ready=0 for 10 cycles in OUT -> out_valid stays 1, in_ready=0, no acc_en. Then out_ready=1 -> IDLE on the next edge, in_ready=1.
- Pulse cfg_start in IDLE -> coef_we high for 4 cycles with coef_addr=0,1,2,3, busy=1, in_ready=0. Then IDLE.
- Raise cfg_start and in_valid in the same cycle -> sample processed first (shift, 4 MACs, out). After out_ready, LOAD runs 4 cycles before in_ready returns to 1.
- Pulse cfg_start 3 times during MAC -> exactly one LOAD of 4 writes after OUT.
- Assert reset during MAC with tap_sel=2 -> all outputs at reset values immediately, no out_valid. The next sample restarts from tap_sel=0. Also cover TAPS=8, TW=3: acc_en for 8 cycles.
